// File: rtl/result_sink.sv
// Result sink: buffers DUT results in a small FIFO behind a ready/valid port and
// steps them onto 16 LEDs, either automatically at a switch-set rate or on a button edge.
module result_sink #(
  parameter int N     = 27,
  parameter int DEPTH = 4,
  parameter int DIVW  = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         out_valid,
  output logic         out_ready,
  input  logic [N-1:0] out0,
  input  logic [15:0]  in,
  output logic [15:0]  led
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} mode_t;

  mode_t          r_mode;
  mode_t          w_mode_nxt;
  logic           w_switch;
  logic           w_auto;
  logic [DIVW-1:0] r_div;
  logic           r_step_q;
  logic [N-1:0]   r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [14:0]    r_disp;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_pop_req;
  logic           w_match;
  logic           w_low_done;
  logic           w_unused_hi;

  // Mode FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mode <= MANUAL;
    else     r_mode <= w_mode_nxt;
  end

  // Mode FSM: next state
  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode)
      MANUAL:  if (in[15])  w_mode_nxt = AUTO;
      AUTO:    if (!in[15]) w_mode_nxt = MANUAL;
      default: w_mode_nxt = MANUAL;
    endcase
  end

  // Mode FSM: outputs
  always_comb begin
    w_auto   = (r_mode == AUTO);
    w_switch = (w_mode_nxt != r_mode);
  end

  // Fire on the last count of the selected window, so in[14:0]=P gives a
  // period of (P+1)*2^(DIVW-15) cycles.
  if (DIVW > 15) begin : g_low
    assign w_low_done = &r_div[DIVW-16:0];
  end else begin : g_nolow
    assign w_low_done = 1'b1;
  end

  assign w_match   = w_low_done && (r_div[DIVW-1:DIVW-15] == in[14:0]);
  assign w_pop_req = !w_switch && (w_auto ? w_match : (in[0] && !r_step_q));

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_push    = out_valid && !w_full;
  assign w_pop     = w_pop_req && !w_empty;
  assign out_ready = !rst && !w_full;
  assign led       = {w_full, r_disp};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div    <= '0;
      r_step_q <= 1'b0;
    end else if (w_switch) begin
      r_div    <= '0;
      r_step_q <= in[0];
    end else if (w_auto) begin
      r_div    <= w_match ? '0 : r_div + 1'b1;
    end else begin
      r_step_q <= in[0];
    end
  end

  // Storage is not reset; discarding entries only needs the pointers cleared.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= out0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_disp   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_disp   <= r_mem[r_rd_ptr][14:0];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Upper result bits are kept in the buffer but never shown.
  assign w_unused_hi = ^r_mem[r_rd_ptr][N-1:15];

endmodule

// File: doc/result_sink.md
Name: result_sink

Overview:
Output-side counterpart of the switch/button stimulus driver. It consumes results from a ready/valid DUT port (e.g. tests_collatz out0) and buffers them in a small FIFO. It applies backpressure through out_ready. Buffered results are shown on 16 LEDs one at a time, stepped either automatically at a switch-programmed rate or manually by a button edge.

Parameters:
N, 27, DUT result width (matches `intN).
DEPTH, 4, FIFO entries; power of two, >=2.
DIVW, 27, rate-divider width, >=15; compare uses div[DIVW-1:DIVW-15].

Ports:
clk  in  1  single clock, all state on posedge.
rst  in  1  asynchronous, active-high reset.
out_valid  in  1  DUT result valid.
out_ready  out  1  sink can accept a result this cycle.
out0  in  N  DUT result data.
in  in  16  switches: in[15]=auto mode; in[14:0]=auto period in auto mode; in[0]=step button in manual mode.
led  out  16  {full, disp[14:0]}.

Behaviour:
- Reset (async, while rst=1): FIFO empty (count=0, rd/wr pointers 0), disp=0, div=0, step_q=0, mode=MANUAL, led=16'h0000.
- out_ready is forced to 0 while rst=1. Otherwise out_ready = (count != DEPTH), decoded from registered count only. There is no combinational path from out_valid or in to out_ready.
- Push: when out_valid && out_ready, out0 (full N bits) is written at wr_ptr at the clock edge. wr_ptr wraps modulo DEPTH. The DUT may hold out_valid high across cycles; each accepted cycle is one entry.
- Pop: disp <= fifo[rd_ptr][14:0]; rd_ptr wraps modulo DEPTH. A pop occurs only if count != 0 at the start of the cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Push into an empty FIFO is not bypassed: the entry becomes poppable the next cycle, so the minimum latency from acceptance to disp update is 1 cycle after the accepting edge.
- Full: no push occurs because out_ready=0. A pop in the same cycle raises out_ready the next cycle.
- Mode FSM, two states, sampled from in[15] each cycle:
  - MANUAL -> AUTO when in[15]=1.
  - AUTO -> MANUAL when in[15]=0.
  - Every transition clears div to 0 and step_q to the current in[0].
- AUTO: div increments each cycle and wraps at 2^DIVW.
  - When div[DIVW-1:DIVW-15] == in[14:0], div clears to 0 and a pop is requested.
  - The request is dropped, not queued, if the FIFO is empty.
  - With in[14:0]=0, a pop is requested every 2^(DIVW-15) cycles.
- MANUAL: step_q <= in[0]. A pop is requested on the cycle in[0]=1 && step_q=0, i.e. on a rising edge.
  - Button synchronisation and debounce are outside this block; in is already synchronous to clk.
- led[15] = (count == DEPTH) and led[14:0] = disp[14:0], both registered state, with no combinational path from in or out0.
- Reset mid-operation: all buffered entries are discarded, and out_ready drops to 0 asynchronously.
- Bits out0[N-1:15] are stored but not displayed; no saturation or truncation flag.

Test Plan:
- Reset: assert rst mid-stream with 2 entries buffered -> out_ready=0 and led=0 immediately. After release: out_ready=1, count=0.
- Manual fill and drain, DEPTH=4: push 5,16,8,4 with out_valid held high and in[15]=0.
  - After the 4th push: out_ready=0 and led[15]=1.
  - Four rising edges on in[0] give led[14:0] = 5, 16, 8, 4 in order.
  - After the first pop, led[15]=0 and out_ready=1.
- Auto rate, DIVW=15 so the compare covers all of div: in=16'h8003, 3 entries (7,22,11) preloaded.
  - Pops occur every 4 cycles, so disp updates at cycles 4, 8 and 12 after entering AUTO.
  - Subsequent matches on the empty FIFO leave disp=11.
- Simultaneous push and pop while full: pop and out_valid in the same cycle.
  - Since out_ready=0 that cycle, no push occurs.
  - The next cycle out_ready=1, the push is accepted, and count returns to 4.
- Empty-pop and mode-switch:
  - Step edge with empty FIFO -> disp unchanged.
  - Toggle in[15] 0->1->0 with in[0] held at 1 -> no spurious pop, and div=0 after each switch.
